// File: rtl/cache_fill_ctrl.sv
// Miss-fill controller: takes one cache miss, issues a block-aligned memory read,
// gathers the 32-bit response beats into a line and writes it to the cache for one cycle.
module cache_fill_ctrl #(
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  miss_valid_i,
  input  logic [31:0]           miss_addr_i,
  output logic                  miss_ready_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [31:0]           mem_req_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [31:0]           mem_resp_data_i,
  output logic                  fill_wr_en_o,
  output logic [31:0]           fill_wr_addr_o,
  output logic [BLOCK_SIZE-1:0] fill_wr_data_o,
  output logic                  busy_o
);

  localparam int BEATS       = BLOCK_SIZE / 32;
  localparam int OFFSET_BITS = $clog2(BLOCK_SIZE / 8);
  localparam int CNT_BITS    = $clog2(BEATS);

  localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
  localparam logic [31:0]         ADDR_MASK = ~((32'd1 << OFFSET_BITS) - 32'd1);

  typedef enum logic [1:0] {IDLE, REQ, BEAT, WRITE} state_t;

  state_t                state_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [31:0]           addr_q;
  logic [BLOCK_SIZE-1:0] line_q;

  // Request and fill share the captured block address; the line is always visible.
  assign mem_req_addr_o = addr_q;
  assign fill_wr_addr_o = addr_q;
  assign fill_wr_data_o = line_q;

  // NOTE: all state, including the handshake outputs, updates with non-blocking
  // assignments so every register samples pre-edge values and sim matches synthesis.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      addr_q          <= '0;
      // NOTE: the line buffer is plain flops, not a RAM, so clearing it on reset is cheap
      // and keeps fill_wr_data_o deterministic after a reset that discards a partial line.
      line_q          <= '0;
      miss_ready_o    <= 1'b1;
      mem_req_valid_o <= 1'b0;
      fill_wr_en_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss_valid_i) begin
            addr_q          <= miss_addr_i & ADDR_MASK;
            cnt_q           <= '0;
            state_q         <= REQ;
            miss_ready_o    <= 1'b0;
            busy_o          <= 1'b1;
            mem_req_valid_o <= 1'b1;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            state_q         <= BEAT;
            mem_req_valid_o <= 1'b0;
          end
        end
        BEAT: begin
          if (mem_resp_valid_i) begin
            line_q[{cnt_q, 5'd0} +: 32] <= mem_resp_data_i;
            cnt_q                       <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q      <= WRITE;
              fill_wr_en_o <= 1'b1;
            end
          end
        end
        WRITE: begin
          state_q      <= IDLE;
          fill_wr_en_o <= 1'b0;
          miss_ready_o <= 1'b1;
          busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Scoreboard bench for cache_fill_ctrl: drivers push expected requests and lines,
// a negedge monitor pops and compares whenever the DUT presents a request or fill.
module tb_cache_fill_ctrl;

  localparam int BLOCK_SIZE  = 256;
  localparam int BEATS       = BLOCK_SIZE / 32;
  localparam int BLOCK_BYTES = BLOCK_SIZE / 8;

  typedef struct {
    logic [31:0]           addr;
    logic [BLOCK_SIZE-1:0] data;
  } fill_t;

  logic                  clk_i = 1'b0;
  logic                  reset_i = 1'b1;
  logic                  miss_valid_i = 1'b0;
  logic [31:0]           miss_addr_i = '0;
  logic                  miss_ready_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i = 1'b0;
  logic [31:0]           mem_req_addr_o;
  logic                  mem_resp_valid_i = 1'b0;
  logic [31:0]           mem_resp_data_i = '0;
  logic                  fill_wr_en_o;
  logic [31:0]           fill_wr_addr_o;
  logic [BLOCK_SIZE-1:0] fill_wr_data_o;
  logic                  busy_o;

  int n_tests = 0;
  int n_fail  = 0;
  int fills_seen = 0;
  int fills_expected = 0;

  logic [31:0] req_q[$];
  fill_t       fill_q[$];

  int gap_tab[BEATS] = '{0, 1, 0, 0, 2, 0, 0, 0};

  cache_fill_ctrl #(.BLOCK_SIZE(BLOCK_SIZE)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .miss_valid_i    (miss_valid_i),
    .miss_addr_i     (miss_addr_i),
    .miss_ready_o    (miss_ready_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i (mem_resp_data_i),
    .fill_wr_en_o    (fill_wr_en_o),
    .fill_wr_addr_o  (fill_wr_addr_o),
    .fill_wr_data_o  (fill_wr_data_o),
    .busy_o          (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [BLOCK_SIZE-1:0] act,
                       input logic [BLOCK_SIZE-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // Reference: block address is the byte address rounded down to a line boundary.
  function automatic logic [31:0] align(input logic [31:0] a);
    return (a / 32'(BLOCK_BYTES)) * 32'(BLOCK_BYTES);
  endfunction

  // Monitor
  logic        prev_valid = 1'b0;
  logic        prev_acc   = 1'b0;
  logic [31:0] prev_addr  = '0;

  always @(negedge clk_i) begin
    if (reset_i) begin
      prev_valid = 1'b0;
    end else begin
      check("ready_vs_busy", BLOCK_SIZE'(miss_ready_o), BLOCK_SIZE'(!busy_o));
      if (prev_valid && !prev_acc) begin
        check("req_valid_held", BLOCK_SIZE'(mem_req_valid_o), BLOCK_SIZE'(1'b1));
        check("req_addr_held", BLOCK_SIZE'(mem_req_addr_o), BLOCK_SIZE'(prev_addr));
      end
      if (mem_req_valid_o) begin
        if (req_q.size() == 0) fail_event("unexpected_req");
        else begin
          check("req_addr", BLOCK_SIZE'(mem_req_addr_o), BLOCK_SIZE'(req_q[0]));
          if (mem_req_ready_i) void'(req_q.pop_front());
        end
      end
      if (fill_wr_en_o) begin
        fills_seen++;
        if (fill_q.size() == 0) fail_event("unexpected_fill");
        else begin
          check("fill_addr", BLOCK_SIZE'(fill_wr_addr_o), BLOCK_SIZE'(fill_q[0].addr));
          check("fill_data", fill_wr_data_o, fill_q[0].data);
          void'(fill_q.pop_front());
        end
      end
      prev_valid = mem_req_valid_o;
      prev_acc   = mem_req_ready_i;
      prev_addr  = mem_req_addr_o;
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_miss_ready"}, BLOCK_SIZE'(miss_ready_o), BLOCK_SIZE'(1'b1));
    check({tag, "_busy"}, BLOCK_SIZE'(busy_o), '0);
    check({tag, "_req_valid"}, BLOCK_SIZE'(mem_req_valid_o), '0);
    check({tag, "_fill_en"}, BLOCK_SIZE'(fill_wr_en_o), '0);
    check({tag, "_fill_addr"}, BLOCK_SIZE'(fill_wr_addr_o), '0);
    check({tag, "_fill_data"}, fill_wr_data_o, '0);
  endtask

  // gap_mode: 0 back-to-back, 1 fixed gap table, 2 random gaps.
  task automatic do_miss(input logic [31:0] addr, input int stall, input int gap_mode,
                         input bit pattern, input bit stray, input bit hold_next,
                         input logic [31:0] next_addr, input int abort_after);
    logic [BLOCK_SIZE-1:0] line;
    logic [31:0]           w;
    int                    gaps;
    bit                    ok;
    line = '0;
    @(posedge clk_i); #1;
    miss_valid_i = 1'b1;
    miss_addr_i  = addr;
    if (stray) begin
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = 32'hDEADBEEF;
    end
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk_i);
      if (miss_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      fail_event("miss_accept_timeout");
      miss_valid_i = 1'b0;
      return;
    end
    req_q.push_back(align(addr));
    @(posedge clk_i); #1;
    miss_valid_i = 1'b0;
    for (int s = 0; s < stall; s++) begin
      mem_req_ready_i = 1'b0;
      @(posedge clk_i); #1;
    end
    mem_req_ready_i = 1'b1;
    @(posedge clk_i); #1;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (gap_mode == 0) gaps = 0;
      else if (gap_mode == 1) gaps = gap_tab[b];
      else gaps = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int g = 0; g < gaps; g++) begin
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = $urandom;
        @(posedge clk_i); #1;
      end
      w = pattern ? 32'(b + 1) * 32'h11111111 : $urandom;
      line[32*b +: 32] = w;
      mem_resp_valid_i = 1'b1;
      mem_resp_data_i  = w;
      if (hold_next && b == BEATS / 2) begin
        miss_valid_i = 1'b1;
        miss_addr_i  = next_addr;
      end
      @(posedge clk_i); #1;
      if (hold_next && b == BEATS / 2) begin
        check("busy_miss_ready_low", BLOCK_SIZE'(miss_ready_o), '0);
        check("busy_flag_high", BLOCK_SIZE'(busy_o), BLOCK_SIZE'(1'b1));
      end
      if (abort_after == b + 1) begin
        mem_resp_data_i = $urandom;
        reset_i = 1'b1;
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        @(negedge clk_i);
        check_reset_state("abort");
        return;
      end
    end
    mem_resp_valid_i = 1'b0;
    fill_q.push_back('{align(addr), line});
    fills_expected++;
    @(negedge clk_i);
    check("fill_one_after_last_beat", BLOCK_SIZE'(fill_wr_en_o), BLOCK_SIZE'(1'b1));
    if (!hold_next) begin
      @(negedge clk_i);
      check("fill_single_pulse", BLOCK_SIZE'(fill_wr_en_o), '0);
      check("ready_after_write", BLOCK_SIZE'(miss_ready_o), BLOCK_SIZE'(1'b1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    @(negedge clk_i);
    check_reset_state("reset");

    // Basic fill: unaligned miss, no stalls, patterned beats.
    do_miss(32'h0000_105C, 0, 0, 1'b1, 1'b0, 1'b0, '0, -1);
    // Request backpressure and response gaps.
    do_miss(32'h0000_3A04, 3, 1, 1'b0, 1'b0, 1'b0, '0, -1);
    // Miss arriving while busy is held and served next.
    do_miss(32'h0000_3000, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, -1);
    do_miss(32'h0000_2000, 0, 0, 1'b0, 1'b0, 1'b0, '0, -1);
    // Stray response traffic in IDLE and REQ.
    do_miss(32'h0000_4444, 2, 0, 1'b1, 1'b1, 1'b0, '0, -1);
    // Reset after half the beats, then a clean fill.
    do_miss(32'h0000_5010, 0, 0, 1'b0, 1'b0, 1'b0, '0, 4);
    do_miss(32'h0000_6020, 0, 0, 1'b1, 1'b0, 1'b0, '0, -1);
    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      do_miss($urandom, int'($urandom_range(0, 3)), 2, 1'b0, 1'(($urandom_range(0, 1))),
              1'b0, '0, -1);
    end

    repeat (3) @(negedge clk_i);
    check("req_queue_drained", BLOCK_SIZE'(req_q.size()), '0);
    check("fill_queue_drained", BLOCK_SIZE'(fill_q.size()), '0);
    check("fill_count", BLOCK_SIZE'(fills_seen), BLOCK_SIZE'(fills_expected));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
